// File: rtl/mips_decode_execute_if.sv
// Bundles the fetch/memory/write-back facing signals of the decode/execute slice.
// The master side drives the instruction and write-back data; the slave is the core slice.
interface mips_decode_execute_if;
  logic [31:0] instruction;
  logic [31:0] writeData;
  logic        jump;
  logic [1:0]  branch;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic [31:0] readRegister1;
  logic [31:0] immediateExtended;
  logic [31:0] resultOutput;
  logic        isAluOutputZero;
  logic [31:0] ioRegisters [32];
  logic [31:0] ioHiLo [2];

  modport master (
    output instruction, writeData,
    input  jump, branch, memRead, memWrite, memToReg,
    input  readRegister1, immediateExtended, resultOutput, isAluOutputZero,
    input  ioRegisters, ioHiLo
  );

  modport slave (
    input  instruction, writeData,
    output jump, branch, memRead, memWrite, memToReg,
    output readRegister1, immediateExtended, resultOutput, isAluOutputZero,
    output ioRegisters, ioHiLo
  );
endinterface

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS slice: main controller, register file and ALU with HI/LO.
// Define MULDIV_EN to implement HI/LO with mult/multu/div/divu/mfhi/mflo.
module mips_decode_execute (
  input logic                  clk,
  input logic                  reset,
  mips_decode_execute_if.slave bus
);
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_FUNC = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SLT  = 4'b0110,
    ALU_LUI  = 4'b0111
  } alu_op_t;

  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign opcode = bus.instruction[31:26];
  assign rs     = bus.instruction[25:21];
  assign rt     = bus.instruction[20:16];
  assign rd     = bus.instruction[15:11];
  assign shamt  = bus.instruction[10:6];
  assign func   = bus.instruction[5:0];
  assign imm    = bus.instruction[15:0];

  logic    reg_dst, alu_src, reg_write, zero_ext;
  logic    mem_read, mem_write, mem_to_reg, jump;
  logic [1:0] branch;
  alu_op_t alu_op;

  always_comb begin : controller
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    zero_ext   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    jump       = 1'b0;
    branch     = 2'b00;
    alu_op     = ALU_ADD;
    if (!reset) begin
      case (opcode)
        6'h00: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = ALU_FUNC; end
        6'h08, 6'h09: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_ADD; end
        6'h0C: begin alu_src = 1'b1; reg_write = 1'b1; zero_ext = 1'b1; alu_op = ALU_AND; end
        6'h0D: begin alu_src = 1'b1; reg_write = 1'b1; zero_ext = 1'b1; alu_op = ALU_OR; end
        6'h0E: begin alu_src = 1'b1; reg_write = 1'b1; zero_ext = 1'b1; alu_op = ALU_XOR; end
        6'h0A: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_SLT; end
        6'h0F: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_LUI; end
        6'h23: begin
          mem_read = 1'b1; mem_to_reg = 1'b1; alu_src = 1'b1; reg_write = 1'b1;
          alu_op = ALU_ADD;
        end
        6'h2B: begin mem_write = 1'b1; alu_src = 1'b1; alu_op = ALU_ADD; end
        6'h04: begin branch = 2'b01; alu_op = ALU_SUB; end
        6'h05: begin branch = 2'b10; alu_op = ALU_SUB; end
        6'h02: jump = 1'b1;
        default: ;
      endcase
    end
  end

  logic [31:0] gpr [32];
  logic [31:0] rs_val, rt_val, sext_imm, zext_imm, op_b, result;
  logic [4:0]  dest;
  logic        func_ok, gpr_we;

  // GPR[0] is only ever cleared by reset, never written, so it always reads 0
  assign rs_val   = gpr[rs];
  assign rt_val   = gpr[rt];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};
  assign op_b     = alu_src ? (zero_ext ? zext_imm : sext_imm) : rt_val;

`ifdef MULDIV_EN
  logic [31:0] hi, lo, hi_next, lo_next;
  logic [63:0] product;
  logic        hilo_we;
`endif

  always_comb begin : alu
    result  = '0;
    func_ok = 1'b1;
`ifdef MULDIV_EN
    product = '0;
    hilo_we = 1'b0;
    hi_next = hi;
    lo_next = lo;
`endif
    case (alu_op)
      ALU_ADD: result = rs_val + op_b;
      ALU_SUB: result = rs_val - op_b;
      ALU_AND: result = rs_val & op_b;
      ALU_OR:  result = rs_val | op_b;
      ALU_XOR: result = rs_val ^ op_b;
      ALU_SLT: result = {31'b0, $signed(rs_val) < $signed(op_b)};
      ALU_LUI: result = {imm, 16'h0000};
      ALU_FUNC: begin
        case (func)
          6'h20, 6'h21: result = rs_val + rt_val;
          6'h22, 6'h23: result = rs_val - rt_val;
          6'h24: result = rs_val & rt_val;
          6'h25: result = rs_val | rt_val;
          6'h26: result = rs_val ^ rt_val;
          6'h27: result = ~(rs_val | rt_val);
          6'h2A: result = {31'b0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: result = {31'b0, rs_val < rt_val};
          6'h00: result = rt_val << shamt;
          6'h02: result = rt_val >> shamt;
          6'h03: result = $signed(rt_val) >>> shamt;
`ifdef MULDIV_EN
          6'h10: result = hi;
          6'h12: result = lo;
          6'h18: begin
            func_ok = 1'b0;
            product = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
            hilo_we = 1'b1;
            hi_next = product[63:32];
            lo_next = product[31:0];
          end
          6'h19: begin
            func_ok = 1'b0;
            product = {32'h0, rs_val} * {32'h0, rt_val};
            hilo_we = 1'b1;
            hi_next = product[63:32];
            lo_next = product[31:0];
          end
          // divide by zero leaves HI/LO untouched
          6'h1A: begin
            func_ok = 1'b0;
            if (rt_val != 32'h0) begin
              hilo_we = 1'b1;
              lo_next = $signed(rs_val) / $signed(rt_val);
              hi_next = $signed(rs_val) % $signed(rt_val);
            end
          end
          6'h1B: begin
            func_ok = 1'b0;
            if (rt_val != 32'h0) begin
              hilo_we = 1'b1;
              lo_next = rs_val / rt_val;
              hi_next = rs_val % rt_val;
            end
          end
`endif
          default: func_ok = 1'b0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign dest   = reg_dst ? rd : rt;
  assign gpr_we = reg_write && func_ok && (dest != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (gpr_we) begin
      gpr[dest] <= bus.writeData;
    end
  end

`ifdef MULDIV_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (hilo_we) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end
  assign bus.ioHiLo[0] = lo;
  assign bus.ioHiLo[1] = hi;
`else
  assign bus.ioHiLo[0] = '0;
  assign bus.ioHiLo[1] = '0;
`endif

  always_comb begin
    for (int i = 0; i < 32; i++) bus.ioRegisters[i] = gpr[i];
  end

  assign bus.jump              = jump;
  assign bus.branch            = branch;
  assign bus.memRead           = mem_read;
  assign bus.memWrite          = mem_write;
  assign bus.memToReg          = mem_to_reg;
  assign bus.readRegister1     = rt_val;
  assign bus.immediateExtended = sext_imm;
  assign bus.resultOutput      = result;
  assign bus.isAluOutputZero   = (result == 32'h0);
endmodule

// File: tb/tb_mips_decode_execute.sv
// Self-checking bench for mips_decode_execute: directed scenarios plus random
// instruction streams checked against an ISA-level reference model.
module tb_mips_decode_execute;
  logic clk = 1'b0;
  logic reset;

  mips_decode_execute_if bus ();
  mips_decode_execute dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  typedef struct packed {
    logic        jump;
    logic [1:0]  branch;
    logic        mr, mw, m2r;
    logic        res_care;
    logic [31:0] res;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] wval;
    logic        hl_we;
    logic [31:0] hi, lo;
  } exp_t;

  exp_t e;

  localparam logic [5:0] OPS [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                                      6'h0A, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
  localparam logic [5:0] FNS [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                      6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18,
                                      6'h19, 6'h1A, 6'h1B, 6'h3E};

  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ISA-level behaviour of one instruction against the model state
  function automatic exp_t model_eval(input logic [31:0] ins, input logic [31:0] mem);
    exp_t r;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] a, b, simm, zimm;
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    int ia, ib;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];   imm = ins[15:0];
    a = m_gpr[rs]; b = m_gpr[rt];
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0000, imm};
    r = '0;
    r.res_care = 1'b1;
    r.hi = m_hi;
    r.lo = m_lo;
    case (op)
      6'h00: begin
        r.dst = rd;
        r.we  = 1'b1;
        case (fn)
          6'h20, 6'h21: r.res = a + b;
          6'h22, 6'h23: r.res = a - b;
          6'h24: r.res = a & b;
          6'h25: r.res = a | b;
          6'h26: r.res = a ^ b;
          6'h27: r.res = ~(a | b);
          6'h2A: r.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          6'h2B: r.res = (a < b) ? 32'd1 : 32'd0;
          6'h00: r.res = b << sh;
          6'h02: r.res = b >> sh;
          6'h03: r.res = 32'($signed(b) >>> sh);
`ifdef MULDIV_EN
          6'h10: r.res = m_hi;
          6'h12: r.res = m_lo;
          6'h18: begin
            ia = int'(a); ib = int'(b); sa = ia; sb = ib; sp = sa * sb;
            r.we = 1'b0; r.hl_we = 1'b1; r.hi = sp[63:32]; r.lo = sp[31:0];
          end
          6'h19: begin
            ua = a; ub = b; up = ua * ub;
            r.we = 1'b0; r.hl_we = 1'b1; r.hi = up[63:32]; r.lo = up[31:0];
          end
          6'h1A: begin
            r.we = 1'b0;
            if (b != 0) begin
              ia = int'(a); ib = int'(b);
              r.hl_we = 1'b1; r.lo = ia / ib; r.hi = ia % ib;
            end
          end
          6'h1B: begin
            r.we = 1'b0;
            if (b != 0) begin r.hl_we = 1'b1; r.lo = a / b; r.hi = a % b; end
          end
`endif
          default: begin r.res = '0; r.we = 1'b0; end
        endcase
      end
      6'h08, 6'h09: begin r.dst = rt; r.we = 1'b1; r.res = a + simm; end
      6'h0C: begin r.dst = rt; r.we = 1'b1; r.res = a & zimm; end
      6'h0D: begin r.dst = rt; r.we = 1'b1; r.res = a | zimm; end
      6'h0E: begin r.dst = rt; r.we = 1'b1; r.res = a ^ zimm; end
      6'h0A: begin r.dst = rt; r.we = 1'b1; r.res = (int'(a) < int'(simm)) ? 32'd1 : 32'd0; end
      6'h0F: begin r.dst = rt; r.we = 1'b1; r.res = {imm, 16'h0000}; end
      6'h23: begin r.dst = rt; r.we = 1'b1; r.mr = 1'b1; r.m2r = 1'b1; r.res = a + simm; end
      6'h2B: begin r.mw = 1'b1; r.res = a + simm; end
      6'h04: begin r.branch = 2'b01; r.res = a - b; end
      6'h05: begin r.branch = 2'b10; r.res = a - b; end
      6'h02: begin r.jump = 1'b1; r.res_care = 1'b0; end
      default: r.res_care = 1'b0;
    endcase
    r.wval = r.m2r ? mem : r.res;
    return r;
  endfunction

  // write-back mux modelled here: writeData carries the model's write-back value
  task automatic drive(input logic [31:0] ins, input logic [31:0] mem);
    @(negedge clk);
    e = model_eval(ins, mem);
    bus.instruction = ins;
    bus.writeData   = e.wval;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      if (e.we && e.dst != 5'd0) m_gpr[e.dst] = e.wval;
      if (e.hl_we) begin m_hi = e.hi; m_lo = e.lo; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(i_type(6'h2B, 5'd0, 5'd1, 16'h0008), 32'h0);
    checks++;
    if ({bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl_sw: got %b want 000000",
               {bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg});
    end
    commit();
    drive(i_type(6'h08, 5'd0, 5'd1, 16'h0005), 32'h0);
    checks++;
    if ({bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl_addi: got %b want 000000",
               {bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg});
    end
    bus.writeData = 32'h5;
    commit();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.ioRegisters[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_gpr%0d: got %h want 00000000", i, bus.ioRegisters[i]);
      end
    end
    checks++;
    if (bus.ioHiLo[0] !== 32'h0 || bus.ioHiLo[1] !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo: got lo=%h hi=%h want 0", bus.ioHiLo[0], bus.ioHiLo[1]);
    end
    reset = 1'b0;
  endtask

  task automatic test_arith();
    drive(i_type(6'h08, 5'd0, 5'd1, 16'h0005), 32'h0);
    commit();
    checks++;
    if (bus.ioRegisters[1] !== 32'h5) begin
      failures++; $display("FAIL addi_gpr1: got %h want 00000005", bus.ioRegisters[1]);
    end
    drive(i_type(6'h08, 5'd0, 5'd2, 16'hFFFD), 32'h0);
    commit();
    checks++;
    if (bus.ioRegisters[2] !== 32'hFFFFFFFD) begin
      failures++; $display("FAIL addi_gpr2: got %h want fffffffd", bus.ioRegisters[2]);
    end
    drive(r_type(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 32'h0);
    checks++;
    if (bus.resultOutput !== 32'h2) begin
      failures++; $display("FAIL add_result: got %h want 00000002", bus.resultOutput);
    end
    checks++;
    if (bus.ioRegisters[3] !== 32'h0) begin
      failures++; $display("FAIL add_same_cycle_old: got %h want 00000000", bus.ioRegisters[3]);
    end
    commit();
    checks++;
    if (bus.ioRegisters[3] !== 32'h2) begin
      failures++; $display("FAIL add_gpr3: got %h want 00000002", bus.ioRegisters[3]);
    end
    drive(i_type(6'h08, 5'd1, 5'd0, 16'h0007), 32'h0);
    commit();
    checks++;
    if (bus.ioRegisters[0] !== 32'h0) begin
      failures++; $display("FAIL write_r0: got %h want 00000000", bus.ioRegisters[0]);
    end
  endtask

  task automatic test_memory();
    drive(i_type(6'h2B, 5'd0, 5'd1, 16'h0008), 32'h0);
    checks++;
    if (bus.memWrite !== 1'b1 || bus.memRead !== 1'b0) begin
      failures++; $display("FAIL sw_strobes: got mw=%b mr=%b want 1 0", bus.memWrite, bus.memRead);
    end
    checks++;
    if (bus.resultOutput !== 32'h8) begin
      failures++; $display("FAIL sw_addr: got %h want 00000008", bus.resultOutput);
    end
    checks++;
    if (bus.readRegister1 !== 32'h5) begin
      failures++; $display("FAIL sw_data: got %h want 00000005", bus.readRegister1);
    end
    commit();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.ioRegisters[i] !== m_gpr[i]) begin
        failures++;
        $display("FAIL sw_no_write_gpr%0d: got %h want %h", i, bus.ioRegisters[i], m_gpr[i]);
      end
    end
    drive(i_type(6'h23, 5'd0, 5'd4, 16'h0008), 32'h1234);
    checks++;
    if (bus.memRead !== 1'b1 || bus.memToReg !== 1'b1 || bus.memWrite !== 1'b0) begin
      failures++;
      $display("FAIL lw_strobes: got mr=%b m2r=%b mw=%b want 1 1 0",
               bus.memRead, bus.memToReg, bus.memWrite);
    end
    commit();
    checks++;
    if (bus.ioRegisters[4] !== 32'h1234) begin
      failures++; $display("FAIL lw_gpr4: got %h want 00001234", bus.ioRegisters[4]);
    end
  endtask

  task automatic test_branch();
    drive(i_type(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'h0);
    checks++;
    if (bus.branch !== 2'b01 || bus.isAluOutputZero !== 1'b1) begin
      failures++;
      $display("FAIL beq: got branch=%b zero=%b want 01 1", bus.branch, bus.isAluOutputZero);
    end
    checks++;
    if (bus.immediateExtended !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL beq_imm: got %h want fffffffe", bus.immediateExtended);
    end
    commit();
    drive(i_type(6'h05, 5'd1, 5'd2, 16'h0010), 32'h0);
    checks++;
    if (bus.branch !== 2'b10 || bus.isAluOutputZero !== 1'b0) begin
      failures++;
      $display("FAIL bne: got branch=%b zero=%b want 10 0", bus.branch, bus.isAluOutputZero);
    end
    commit();
    drive(i_type(6'h02, 5'd3, 5'd7, 16'h1234), 32'h0);
    checks++;
    if (bus.jump !== 1'b1 || bus.branch !== 2'b00) begin
      failures++; $display("FAIL jump: got j=%b br=%b want 1 00", bus.jump, bus.branch);
    end
    commit();
  endtask

  task automatic test_muldiv();
    drive(i_type(6'h0F, 5'd0, 5'd6, 16'h0001), 32'h0);
    commit();
    drive(r_type(6'h18, 5'd6, 5'd6, 5'd7, 5'd0), 32'h0);
    checks++;
    if (bus.resultOutput !== 32'h0) begin
      failures++; $display("FAIL mult_result: got %h want 00000000", bus.resultOutput);
    end
    commit();
    checks++;
    if (bus.ioRegisters[7] !== 32'h0) begin
      failures++; $display("FAIL mult_no_gpr: got %h want 00000000", bus.ioRegisters[7]);
    end
`ifdef MULDIV_EN
    checks++;
    if (bus.ioHiLo[1] !== 32'h1 || bus.ioHiLo[0] !== 32'h0) begin
      failures++;
      $display("FAIL mult_hilo: got hi=%h lo=%h want 1 0", bus.ioHiLo[1], bus.ioHiLo[0]);
    end
    drive(i_type(6'h08, 5'd0, 5'd7, 16'h0007), 32'h0);
    commit();
    drive(r_type(6'h1A, 5'd7, 5'd0, 5'd0, 5'd0), 32'h0);
    commit();
    checks++;
    if (bus.ioHiLo[1] !== 32'h1 || bus.ioHiLo[0] !== 32'h0) begin
      failures++;
      $display("FAIL div0_hilo: got hi=%h lo=%h want 1 0", bus.ioHiLo[1], bus.ioHiLo[0]);
    end
    drive(i_type(6'h08, 5'd0, 5'd8, 16'h0002), 32'h0);
    commit();
    drive(r_type(6'h1A, 5'd7, 5'd8, 5'd0, 5'd0), 32'h0);
    commit();
    checks++;
    if (bus.ioHiLo[1] !== 32'h1 || bus.ioHiLo[0] !== 32'h3) begin
      failures++;
      $display("FAIL div_hilo: got hi=%h lo=%h want 1 3", bus.ioHiLo[1], bus.ioHiLo[0]);
    end
    drive(r_type(6'h10, 5'd0, 5'd0, 5'd5, 5'd0), 32'h0);
    commit();
    checks++;
    if (bus.ioRegisters[5] !== 32'h1) begin
      failures++; $display("FAIL mfhi_gpr5: got %h want 00000001", bus.ioRegisters[5]);
    end
`else
    checks++;
    if (bus.ioHiLo[1] !== 32'h0 || bus.ioHiLo[0] !== 32'h0) begin
      failures++;
      $display("FAIL nomuldiv_hilo: got hi=%h lo=%h want 0 0", bus.ioHiLo[1], bus.ioHiLo[0]);
    end
    drive(r_type(6'h10, 5'd0, 5'd0, 5'd5, 5'd0), 32'h0);
    checks++;
    if (bus.resultOutput !== 32'h0) begin
      failures++; $display("FAIL nomuldiv_mfhi_result: got %h want 00000000", bus.resultOutput);
    end
    commit();
    checks++;
    if (bus.ioRegisters[5] !== 32'h0) begin
      failures++; $display("FAIL nomuldiv_mfhi_gpr: got %h want 00000000", bus.ioRegisters[5]);
    end
`endif
  endtask

  task automatic test_logic_shift();
    drive(i_type(6'h0D, 5'd0, 5'd9, 16'h8000), 32'h0);
    commit();
    checks++;
    if (bus.ioRegisters[9] !== 32'h00008000) begin
      failures++; $display("FAIL ori_zext: got %h want 00008000", bus.ioRegisters[9]);
    end
    drive(i_type(6'h0F, 5'd0, 5'd10, 16'h8000), 32'h0);
    commit();
    drive(r_type(6'h03, 5'd0, 5'd10, 5'd11, 5'd4), 32'h0);
    checks++;
    if (bus.resultOutput !== 32'hF8000000) begin
      failures++; $display("FAIL sra_result: got %h want f8000000", bus.resultOutput);
    end
    commit();
    drive(i_type(6'h0F, 5'd0, 5'd12, 16'h1234), 32'h0);
    checks++;
    if (bus.resultOutput !== 32'h12340000) begin
      failures++; $display("FAIL lui_result: got %h want 12340000", bus.resultOutput);
    end
    commit();
    drive({6'h3F, 5'd1, 5'd13, 16'hFFFF}, 32'hDEADBEEF);
    checks++;
    if ({bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg} !== 6'b0) begin
      failures++;
      $display("FAIL unknown_op_ctrl: got %b want 000000",
               {bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg});
    end
    bus.writeData = 32'hDEADBEEF;
    commit();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.ioRegisters[i] !== m_gpr[i]) begin
        failures++;
        $display("FAIL unknown_op_gpr%0d: got %h want %h", i, bus.ioRegisters[i], m_gpr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      op = OPS[$urandom_range(0, 15)];
      fn = FNS[$urandom_range(0, 19)];
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      if (fn == 6'h1A && m_gpr[rs] == 32'h80000000 && m_gpr[rt] == 32'hFFFFFFFF) fn = 6'h21;
      if (op == 6'h00)
        ins = r_type(fn, rs, rt, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      else
        ins = i_type(op, rs, rt, 16'($urandom()));
      drive(ins, $urandom());
      checks++;
      if ({bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg} !==
          {e.jump, e.branch, e.mr, e.mw, e.m2r}) begin
        failures++;
        $display("FAIL rand_ctrl ins=%h: got %b want %b", ins,
                 {bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg},
                 {e.jump, e.branch, e.mr, e.mw, e.m2r});
      end
      if (e.res_care) begin
        checks++;
        if (bus.resultOutput !== e.res || bus.isAluOutputZero !== (e.res == 32'h0)) begin
          failures++;
          $display("FAIL rand_result ins=%h: got %h z=%b want %h", ins,
                   bus.resultOutput, bus.isAluOutputZero, e.res);
        end
      end
      checks++;
      if (bus.readRegister1 !== m_gpr[rt] || bus.immediateExtended !== {{16{ins[15]}}, ins[15:0]})
      begin
        failures++;
        $display("FAIL rand_rt_imm ins=%h: got %h %h want %h", ins,
                 bus.readRegister1, bus.immediateExtended, m_gpr[rt]);
      end
      commit();
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (bus.ioRegisters[i] !== m_gpr[i]) begin
          failures++;
          $display("FAIL rand_gpr%0d ins=%h: got %h want %h", i, ins, bus.ioRegisters[i], m_gpr[i]);
        end
      end
      checks++;
`ifdef MULDIV_EN
      if (bus.ioHiLo[1] !== m_hi || bus.ioHiLo[0] !== m_lo) begin
`else
      if (bus.ioHiLo[1] !== 32'h0 || bus.ioHiLo[0] !== 32'h0) begin
`endif
        failures++;
        $display("FAIL rand_hilo ins=%h: got hi=%h lo=%h want hi=%h lo=%h", ins,
                 bus.ioHiLo[1], bus.ioHiLo[0], m_hi, m_lo);
      end
    end
  endtask

  task automatic test_midprogram_reset();
    drive(r_type(6'h20, 5'd1, 5'd1, 5'd14, 5'd0), 32'h0);
    checks++;
    if (bus.ioRegisters[1] === 32'h0 && m_gpr[1] !== 32'h0) begin
      failures++; $display("FAIL midreset_early: got %h want %h", bus.ioRegisters[1], m_gpr[1]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.jump, bus.branch, bus.memRead, bus.memWrite, bus.memToReg} !== 6'b0) begin
      failures++; $display("FAIL midreset_ctrl: got nonzero controls want 000000");
    end
    commit();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.ioRegisters[i] !== 32'h0) begin
        failures++; $display("FAIL midreset_gpr%0d: got %h want 00000000", i, bus.ioRegisters[i]);
      end
    end
    checks++;
    if (bus.ioHiLo[0] !== 32'h0 || bus.ioHiLo[1] !== 32'h0) begin
      failures++;
      $display("FAIL midreset_hilo: got lo=%h hi=%h want 0", bus.ioHiLo[0], bus.ioHiLo[1]);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.instruction = '0;
    bus.writeData   = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi = '0;
    m_lo = '0;
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_muldiv();
    test_logic_shift();
    test_random();
    test_midprogram_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_decode_execute.md
# mips_decode_execute

Single-cycle MIPS core slice that combines the main controller, the register-file/decode stage and the ALU/HI-LO execute stage. It takes the current 32-bit instruction from fetch and the write-back data from the write-back mux. It produces:
- all control strobes for fetch, memory and write-back;
- the ALU result and zero flag;
- the store data;
- the sign-extended immediate.

Architectural state (32 GPRs, HI, LO) is exposed for debug.

## Interface
- Parameters: none.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high. Clears all GPRs, HI and LO. Forces every control output to 0.
- `instruction` in 32: current instruction (op [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], func [5:0], imm [15:0]).
- `writeData` in 32: value written to the destination GPR at the clock edge.
- `jump` out 1: j instruction.
- `branch` out 2: 01 = beq, 10 = bne, 00 = none.
- `memRead` out 1: load strobe.
- `memWrite` out 1: store strobe.
- `memToReg` out 1: write-back selects memory data.
- `readRegister1` out 32: GPR[rt], used as store data.
- `immediateExtended` out 32: sign-extended imm.
- `resultOutput` out 32: ALU result, also the memory address.
- `isAluOutputZero` out 1: resultOutput == 0.
- `ioRegisters` out 32x[32]: GPR debug view.
- `ioHiLo` out 32x[2]: [0] = LO, [1] = HI.

## Operation
- Controller decode (combinational, all 0 while `reset` is high). Each opcode sets regDst / aluSrc / regWrite / memory / branch signals and an aluOp code:

| Opcode | Instruction | Controls | aluOp |
|---|---|---|---|
| 0x00 | R-type | regDst = 1, regWrite = 1 | FUNC |
| 0x08, 0x09 | addi / addiu | aluSrc, regWrite | ADD |
| 0x0C | andi | aluSrc, regWrite | AND |
| 0x0D | ori | aluSrc, regWrite | OR |
| 0x0E | xori | aluSrc, regWrite | XOR |
| 0x0A | slti | aluSrc, regWrite | SLT |
| 0x0F | lui | aluSrc, regWrite | LUI |
| 0x23 | lw | memRead, memToReg, aluSrc, regWrite | ADD |
| 0x2B | sw | memWrite, aluSrc | ADD |
| 0x04 | beq | branch = 01 | SUB |
| 0x05 | bne | branch = 10 | SUB |
| 0x02 | j | jump = 1 | — |

  Any other opcode: all controls 0 (NOP).
- aluOp encoding: ADD 0000, SUB 0001, FUNC 0010, AND 0011, OR 0100, XOR 0101, SLT 0110, LUI 0111.
- Operand B: aluSrc ? immediate : GPR[rt].
  - andi, ori and xori use the zero-extended imm.
  - All other immediate instructions use the sign-extended imm.
  - lui result is {imm, 16'h0}.
- R-type func codes:
  - add/addu 0x20/0x21, sub/subu 0x22/0x23.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A (signed), sltu 0x2B (unsigned).
  - sll 0x00, srl 0x02, sra 0x03: shift rt by shamt.
  - mfhi 0x10, mflo 0x12.
  - mult 0x18, multu 0x19, div 0x1A, divu 0x1B.
- Arithmetic: 32-bit, wrap-around, no overflow traps.
- mult/multu:
  - 64-bit product; HI = upper word, LO = lower word.
  - resultOutput = 0.
- div/divu:
  - LO = quotient, HI = remainder; divu is unsigned.
  - Divide by zero leaves HI/LO unchanged.
  - resultOutput = 0.
- GPR write suppression: regWrite is internally gated off for mult, multu, div, divu and any unknown func. Unknown func gives resultOutput = 0.
- Register file:
  - 32x32, asynchronous read of rs and rt.
  - Destination = regDst ? rd : rt.
  - Writes to register 0 are ignored; GPR[0] always reads 0.

## Timing
- Everything except GPR/HI/LO writes is combinational from `instruction` and current state.
- GPR write, HI/LO write: on the rising edge of `clk` when `reset` is low.
- Reads in the same cycle as a write return the old value; the new value is visible the next cycle.
- `reset` high at an edge:
  - All GPRs, HI and LO become 0.
  - Pending writes in that cycle are discarded.
  - Reset applied mid-program takes effect at the next edge.
- Latency: one instruction per cycle; results architecturally visible one edge after issue.

## Configuration
- `MULDIV_EN` defined: HI/LO registers and mult, multu, div, divu, mfhi, mflo are implemented as above.
- `MULDIV_EN` undefined:
  - Those six funcs are treated as unknown (result 0, no GPR write).
  - No HI/LO storage; `ioHiLo` is driven to 0.

## Test plan
- Reset: hold `reset` 1 cycle → all `ioRegisters` = 0, `ioHiLo` = 0, all control outputs 0 while asserted.
- addi $1,$0,5 then addi $2,$0,-3 then add $3,$1,$2 → GPR1 = 5, GPR2 = 0xFFFFFFFD, GPR3 = 2. A write to $0 leaves GPR0 = 0.
- sw $1,8($0) → memWrite = 1, resultOutput = 8, readRegister1 = 5, no GPR change. lw $4,8($0) → memRead = 1, memToReg = 1; `writeData` = 0x1234 lands in GPR4 next edge.
- beq $1,$1 with imm = 0xFFFE → branch = 01, isAluOutputZero = 1, immediateExtended = 0xFFFFFFFE. bne $1,$2 → branch = 10, isAluOutputZero = 0.
- With `MULDIV_EN`: mult of 0x10000 × 0x10000 → HI = 1, LO = 0, no GPR write. div 7/0 → HI/LO unchanged. div 7/2 → LO = 3, HI = 1. mfhi $5 → GPR5 = 1.
- Logic/shift: ori imm = 0x8000 on $0 → 0x00008000. sra of 0x80000000 by 4 → 0xF8000000. lui 0x1234 → 0x12340000. Unknown opcode 0x3F → all controls 0, no state change.
